// File: rtl/dct_row_collector.sv
// Collects LANES-wide DCT butterfly vectors into a ROWS-slot block and hands the block downstream.
// Define DCT_ROW_PINGPONG_EN for a second bank so filling continues while a block waits to drain.
module dct_row_collector #(
   parameter int WIDTH = 8,
   parameter int LANES = 7,
   parameter int ROWS  = 4,
   parameter int SEL_W = $clog2(ROWS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [LANES*WIDTH-1:0]      in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [SEL_W-1:0]            Sele,
   input  logic                        sel_mode,
   output logic [ROWS*LANES*WIDTH-1:0] out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ROWS-1:0]             row_valid,
   output logic                        overwrite_err
);

   localparam int ROW_W = LANES * WIDTH;
   localparam int BLK_W = ROWS * ROW_W;

   logic [BLK_W-1:0] out_data_q, out_data_d;
   logic [ROWS-1:0]  row_valid_q, row_valid_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             err_q, err_d;
   logic             mode_q, mode_d;

   logic             accept_s, drain_s, frame_empty_s, ext_s, wr_en_s;
   logic [SEL_W-1:0] slot_s;
`ifdef DCT_ROW_PINGPONG_EN
   logic [BLK_W-1:0] wr_data_q, wr_data_d;
   logic             wr_full_s, swap_s;
`endif

   assign accept_s      = in_valid && in_ready_q;
   assign drain_s       = out_valid_q && out_ready;
   assign frame_empty_s = (row_valid_q == {ROWS{1'b0}});
   // The first beat of a frame samples sel_mode directly; later beats use the latched mode.
   assign ext_s         = frame_empty_s ? sel_mode : mode_q;
   assign slot_s        = ext_s ? Sele : ptr_q;
   assign wr_en_s       = accept_s && (int'(slot_s) < ROWS);

   // Next-state for slots, pointer, mode, error flag and handshake.
   always_comb begin
      out_data_d  = out_data_q;
      row_valid_d = row_valid_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      err_d       = err_q;
      mode_d      = mode_q;
      in_ready_d  = in_ready_q;
`ifdef DCT_ROW_PINGPONG_EN
      wr_data_d   = wr_data_q;
      wr_full_s   = 1'b0;
      swap_s      = 1'b0;
`endif
      if (accept_s) begin
         if (frame_empty_s) begin
            mode_d = sel_mode;
         end else begin
            mode_d = mode_q;
         end
         if (!ext_s) begin
            ptr_d = (ptr_q == SEL_W'(ROWS - 1)) ? {SEL_W{1'b0}} : ptr_q + SEL_W'(1);
         end else begin
            ptr_d = ptr_q;
         end
      end else begin
         mode_d = mode_q;
      end
      for (int r = 0; r < ROWS; r++) begin
         if (wr_en_s && (slot_s == SEL_W'(r))) begin
            row_valid_d[r] = 1'b1;
`ifdef DCT_ROW_PINGPONG_EN
            wr_data_d[r*ROW_W +: ROW_W] = in_data;
`else
            out_data_d[r*ROW_W +: ROW_W] = in_data;
`endif
            if (ext_s && row_valid_q[r]) begin
               err_d = 1'b1;
            end else begin
               err_d = err_d;
            end
         end else begin
            row_valid_d[r] = row_valid_d[r];
         end
      end
`ifdef DCT_ROW_PINGPONG_EN
      // A full write bank moves to the read side when that side is empty or draining now.
      wr_full_s = &row_valid_d;
      swap_s    = wr_full_s && (!out_valid_q || drain_s);
      if (swap_s) begin
         out_data_d  = wr_data_d;
         out_valid_d = 1'b1;
         row_valid_d = {ROWS{1'b0}};
         ptr_d       = {SEL_W{1'b0}};
      end else if (drain_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      in_ready_d = !(out_valid_d && (&row_valid_d));
`else
      if (drain_s) begin
         row_valid_d = {ROWS{1'b0}};
         ptr_d       = {SEL_W{1'b0}};
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = &row_valid_d;
      end
      in_ready_d = !out_valid_d;
`endif
   end

   // State registers; in_ready comes up on the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= {BLK_W{1'b0}};
         row_valid_q <= {ROWS{1'b0}};
         ptr_q       <= {SEL_W{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         err_q       <= 1'b0;
         mode_q      <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         row_valid_q <= row_valid_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         err_q       <= err_d;
         mode_q      <= mode_d;
      end
   end

`ifdef DCT_ROW_PINGPONG_EN
   // Write bank storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_data_q <= {BLK_W{1'b0}};
      end else begin
         wr_data_q <= wr_data_d;
      end
   end
`endif

   assign out_data      = out_data_q;
   assign row_valid     = row_valid_q;
   assign out_valid     = out_valid_q;
   assign in_ready      = in_ready_q;
   assign overwrite_err = err_q;

endmodule

// File: doc/dct_row_collector.md
Name: dct_row_collector

Overview:
- Sequential, parametrised successor to the DCT butterfly 1-to-N row selector.
- Accepts one butterfly result vector per beat: LANES lanes of sum/difference terms A,C,F,B,D,E,G.
- Writes each vector into one of ROWS registered row slots, selected either by an internal auto-increment pointer or by an external select.
- Presents the complete ROWS x LANES block to the next DCT stage with a valid/ready handshake.
- All outputs are registered; outputs hold their value until drained, and no output is left undriven on any select value.

Parameters:
- WIDTH, 8, signed bit width of each lane.
- LANES, 7, lanes per input vector.
- ROWS, 4, number of row slots per block (2..16).
- SEL_W, $clog2(ROWS), width of the row select and pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  LANES*WIDTH  packed signed lanes; lane 0 in the LSBs.
- in_valid  input  1  in_data valid.
- in_ready  output  1  collector can accept a beat.
- Sele  input  SEL_W  external row select; used only in external mode.
- sel_mode  input  1  0 = auto-increment pointer, 1 = external Sele.
- out_data  output  ROWS*LANES*WIDTH  block; row r at [r*LANES*WIDTH +: LANES*WIDTH].
- out_valid  output  1  all ROWS slots filled; block valid.
- out_ready  input  1  downstream accepts the block.
- row_valid  output  ROWS  per-slot filled flags.
- overwrite_err  output  1  sticky flag: an external-mode write hit an already-filled slot.

Behaviour:
- Reset (asynchronous, on rst_n low): out_data=0, row_valid=0, out_valid=0, overwrite_err=0, pointer=0, frame mode register=0. in_ready=1 from the first clock after rst_n deasserts.
- Beat acceptance: a beat is accepted on a rising edge when in_valid && in_ready. in_ready = !out_valid (base build).
- Write latency: a beat accepted at edge t is visible in its out_data row and its row_valid bit after edge t.
- Frame mode: the mode register captures sel_mode on the first accepted beat of a frame (all row_valid bits 0). Changes to sel_mode mid-frame are ignored until the block drains.
- Auto mode: the beat writes to slot pointer, then pointer increments and wraps ROWS-1 -> 0. Sele is ignored.
- External mode: the beat writes to slot Sele.
  - Sele >= ROWS (non-power-of-2 ROWS): beat is accepted and dropped; nothing is written.
  - Write to a slot whose row_valid is already 1: data is overwritten, row_valid stays 1, overwrite_err sets and stays set until reset.
- Block completion: out_valid = &row_valid as a registered flag. It rises on the edge that fills the last empty slot.
- Drain: on an edge with out_valid && out_ready:
  - row_valid clears to 0, out_valid clears to 0, pointer returns to 0.
  - out_data keeps its old value; it is not cleared.
  - in_ready returns to 1 in the next cycle.
- Stall: while out_valid=1 and out_ready=0, out_data and row_valid are held and in_ready=0.
- Arithmetic: none; data is passed bit-exact with no sign extension or truncation.

Optional Feature:
- Macro: DCT_ROW_PINGPONG_EN.
- Defined:
  - Two banks of ROWS slots. Input fills the write bank while the read bank is presented on out_data.
  - Bank roles swap when the write bank is full and the read bank is empty or draining on the same edge.
  - in_ready = 0 only when both banks are full.
  - Simultaneous drain and fill of the last slot: the swap occurs on that edge with no bubble, so out_valid stays 1.
  - row_valid reports the write bank.
- Undefined: single bank, exactly as in Behaviour above.

Test Plan:
- Reset: rst_n=0 mid-frame after 2 of 4 beats -> row_valid=4'b0000, out_valid=0, pointer=0 immediately. The next 4 auto beats fill rows 0..3 in order.
- Auto fill: 4 beats with lane0 = 8'h11, 8'h22, 8'h33, 8'h44 and out_ready=0 -> out_valid=1 one edge after the 4th beat, rows 0..3 lane0 = 11/22/33/44, in_ready=0. A 5th beat is not accepted.
- Drain: out_ready=1 for one cycle -> row_valid=0, out_valid=0, in_ready=1 next cycle, out_data unchanged.
- External mode: Sele = 3,1,0,2 with data -8, 127, -128, 5 -> each row holds its value. out_valid rises after the Sele=2 beat. overwrite_err=0.
- Overwrite: external writes Sele=1 twice, with 8'h0A then 8'h0B -> row1=8'h0B, row_valid[1]=1, overwrite_err=1 and it persists after drain.
- Ping-pong (macro on): continuous in_valid, out_ready=1 -> in_ready stays 1 and out_valid is high every 4th cycle with no stall. With out_ready=0, in_ready drops after 8 beats.
